multicycle_controller: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback over a single shared memory port. It drives the ALU class select (aluOp) that alu_op_unit turns into an ALU operation, and it steers all datapath muxes and write enables. It also traps on illegal opcodes and on alu_op_unit error.

---
 rtl/multicycle_controller_pkg.sv | 69 ++++++
 rtl/multicycle_controller_main_decoder.sv | 26 ++
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types for the RV32I multi-cycle controller: flag and ALU-class types,
// FSM state encodings, instruction classes, opcodes and mux select encodings.
package definitions;
    typedef logic flag_t;
endpackage

package alu_definitions;
    typedef enum logic [1:0] {
        DEF_ADD = 2'd0,
        TYPE_I  = 2'd1,
        TYPE_R  = 2'd2,
        PASS_S1 = 2'd3
    } aluOp_t;
endpackage

package ctrl_definitions;
    typedef logic [2:0] state_t;

    localparam state_t ST_INIT   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_MEM    = 3'd4;
    localparam state_t ST_WB     = 3'd5;
    localparam state_t ST_TRAP   = 3'd6;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_LUI    = 3'd7
    } instr_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        SRCA_RS1   = 2'd0,
        SRCA_PC    = 2'd1,
        SRCA_OLDPC = 2'd2,
        SRCA_IMM   = 2'd3
    } srcA_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } srcB_t;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MDR    = 2'd1,
        WB_PC     = 2'd2
    } wbSel_t;

    // Classes whose ALU result is checked against alu_op_unit's error flag.
    function automatic logic alu_checked(input instr_class_t cls);
        return (cls == CLS_R) || (cls == CLS_I);
    endfunction
endpackage

// File: rtl/multicycle_controller_main_decoder.sv
// Combinational opcode decoder: maps IR[6:0] to an instruction class and
// flags opcodes outside the supported RV32I subset.
module main_decoder
    import ctrl_definitions::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class,
    output logic         legal
);

    always_comb begin
        instr_class = CLS_NONE;
        legal       = 1'b1;
        case (opcode)
            OPC_R:      instr_class = CLS_R;
            OPC_I:      instr_class = CLS_I;
            OPC_LOAD:   instr_class = CLS_LOAD;
            OPC_STORE:  instr_class = CLS_STORE;
            OPC_BRANCH: instr_class = CLS_BRANCH;
            OPC_JAL:    instr_class = CLS_JAL;
            OPC_LUI:    instr_class = CLS_LUI;
            default:    legal       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory port and traps on illegal opcodes or ALU errors.
module multicycle_controller
    import definitions::*;
    import alu_definitions::*;
    import ctrl_definitions::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [6:0]           opcode,
    input  flag_t                alu_err,
    input  logic                 br_taken,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_write,
    output logic                 mdr_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output aluOp_t               alu_op,
    output logic [1:0]           src_a,
    output logic [1:0]           src_b,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret,
    output state_t               state
);

    // Memory handshake: mem_req is the valid; the transfer completes in the
    // cycle mem_ready is high while mem_req is high. Until then the FSM holds
    // its state, so mem_req, mem_we and addr_sel cannot change mid-request.

    state_t       state_q;
    state_t       state_d;
    instr_class_t cls_q;
    instr_class_t dec_class;
    logic         dec_legal;
    logic         retire;

    main_decoder u_main_decoder (
        .opcode      (opcode),
        .instr_class (dec_class),
        .legal       (dec_legal)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_INIT;
            cls_q   <= CLS_NONE;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q <= dec_class;
            end
            if (retire) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

    assign state  = state_q;
    assign pc_src = 1'b0;

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        mdr_write = 1'b0;
        pc_write  = 1'b0;
        alu_op    = DEF_ADD;
        src_a     = SRCA_RS1;
        src_b     = SRCB_RS2;
        reg_write = 1'b0;
        wb_sel    = WB_ALUOUT;
        trap      = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                src_a   = SRCA_PC;
                src_b   = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = dec_legal ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                case (cls_q)
                    CLS_R: begin
                        alu_op  = TYPE_R;
                        state_d = ST_WB;
                    end
                    CLS_I: begin
                        alu_op  = TYPE_I;
                        src_b   = SRCB_IMM;
                        state_d = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        src_b   = SRCB_IMM;
                        state_d = ST_MEM;
                    end
                    CLS_LUI: begin
                        alu_op  = PASS_S1;
                        src_a   = SRCA_IMM;
                        state_d = ST_WB;
                    end
                    CLS_BRANCH: begin
                        src_a    = SRCA_OLDPC;
                        src_b    = SRCB_IMM;
                        pc_write = br_taken;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_JAL: begin
                        // PC already advanced to PC+4 in FETCH, so it is the link value.
                        src_a     = SRCA_OLDPC;
                        src_b     = SRCB_IMM;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_TRAP;
                    end
                endcase
                if (alu_checked(cls_q) && alu_err) begin
                    pc_write  = 1'b0;
                    reg_write = 1'b0;
                    retire    = 1'b0;
                    state_d   = ST_TRAP;
                end
            end

            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        mdr_write = 1'b1;
                        state_d   = ST_WB;
                    end
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = (cls_q == CLS_LOAD) ? WB_MDR : WB_ALUOUT;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_TRAP: begin
                trap    = 1'b1;
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected state, control
// outputs and retire count for each instruction class, trap and reset cases.
module tb_multicycle_controller;
    import alu_definitions::*;
    import ctrl_definitions::*;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       alu_err = 1'b0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src;
    aluOp_t     alu_op;
    logic [1:0] src_a, src_b, wb_sel;
    logic       reg_write, trap;
    logic [3:0] instret;
    state_t     state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.INSTRET_W(4)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .opcode    (opcode),
        .alu_err   (alu_err),
        .br_taken  (br_taken),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_write  (ir_write),
        .mdr_write (mdr_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .trap      (trap),
        .instret   (instret),
        .state     (state)
    );

    wire [16:0] outs = {mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src,
                        alu_op, src_a, src_b, reg_write, wb_sel, trap};
    wire [23:0] obs = {state, outs, instret};

    // Field order: mem_req mem_we addr_sel ir_write mdr_write pc_write (pc_src=0)
    // alu_op src_a src_b reg_write wb_sel trap.
    function automatic logic [16:0] ov(input int mreq, input int mwe, input int asel,
                                       input int irw, input int mdrw, input int pcw,
                                       input int aop, input int sa, input int sb,
                                       input int rw, input int wbs, input int tr);
        return {1'(mreq), 1'(mwe), 1'(asel), 1'(irw), 1'(mdrw), 1'(pcw), 1'b0,
                2'(aop), 2'(sa), 2'(sb), 1'(rw), 2'(wbs), 1'(tr)};
    endfunction

    localparam logic [16:0] O_IDLE       = ov(0, 0, 0, 0, 0, 0, DEF_ADD, 0, 0, 0, 0, 0);
    localparam logic [16:0] O_FETCH_WAIT = ov(1, 0, 0, 0, 0, 0, DEF_ADD, 1, 2, 0, 0, 0);
    localparam logic [16:0] O_FETCH_GO   = ov(1, 0, 0, 1, 0, 1, DEF_ADD, 1, 2, 0, 0, 0);
    localparam logic [16:0] O_EXEC_I     = ov(0, 0, 0, 0, 0, 0, TYPE_I,  0, 1, 0, 0, 0);
    localparam logic [16:0] O_EXEC_R     = ov(0, 0, 0, 0, 0, 0, TYPE_R,  0, 0, 0, 0, 0);
    localparam logic [16:0] O_EXEC_MEM   = ov(0, 0, 0, 0, 0, 0, DEF_ADD, 0, 1, 0, 0, 0);
    localparam logic [16:0] O_EXEC_LUI   = ov(0, 0, 0, 0, 0, 0, PASS_S1, 3, 0, 0, 0, 0);
    localparam logic [16:0] O_BR_NT      = ov(0, 0, 0, 0, 0, 0, DEF_ADD, 2, 1, 0, 0, 0);
    localparam logic [16:0] O_BR_T       = ov(0, 0, 0, 0, 0, 1, DEF_ADD, 2, 1, 0, 0, 0);
    localparam logic [16:0] O_JAL        = ov(0, 0, 0, 0, 0, 1, DEF_ADD, 2, 1, 1, 2, 0);
    localparam logic [16:0] O_LD_WAIT    = ov(1, 0, 1, 0, 0, 0, DEF_ADD, 0, 0, 0, 0, 0);
    localparam logic [16:0] O_LD_GO      = ov(1, 0, 1, 0, 1, 0, DEF_ADD, 0, 0, 0, 0, 0);
    localparam logic [16:0] O_ST         = ov(1, 1, 1, 0, 0, 0, DEF_ADD, 0, 0, 0, 0, 0);
    localparam logic [16:0] O_WB_ALU     = ov(0, 0, 0, 0, 0, 0, DEF_ADD, 0, 0, 1, 0, 0);
    localparam logic [16:0] O_WB_MDR     = ov(0, 0, 0, 0, 0, 0, DEF_ADD, 0, 0, 1, 1, 0);
    localparam logic [16:0] O_TRAP       = ov(0, 0, 0, 0, 0, 0, DEF_ADD, 0, 0, 0, 0, 1);

    // Leaves rstN released at a falling edge with the FSM in INIT.
    task automatic do_reset();
        @(negedge clk);
        rstN      = 1'b0;
        mem_ready = 1'b0;
        br_taken  = 1'b0;
        alu_err   = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN      = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== {ST_INIT, O_IDLE, 4'd0}) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs, {ST_INIT, O_IDLE, 4'd0});
        end
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic test_addi();
        state_t      es[6] = '{ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH};
        logic [16:0] eo[6] = '{O_IDLE, O_FETCH_GO, O_IDLE, O_EXEC_I, O_WB_ALU, O_FETCH_WAIT};
        logic        mr[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  ei[6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        do_reset();
        opcode = 7'b0010011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (obs !== {es[i], eo[i], ei[i]}) begin
                failures++;
                $display("FAIL addi cyc=%0d got=%h exp=%h", i, obs, {es[i], eo[i], ei[i]});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_wait();
        state_t      es[10] = '{ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MEM,
                                ST_MEM, ST_MEM, ST_WB, ST_FETCH};
        logic [16:0] eo[10] = '{O_IDLE, O_FETCH_GO, O_IDLE, O_EXEC_MEM, O_LD_WAIT, O_LD_WAIT,
                                O_LD_WAIT, O_LD_GO, O_WB_MDR, O_FETCH_WAIT};
        logic        mr[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  ei[10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        do_reset();
        opcode = 7'b0000011;
        for (int i = 0; i < 10; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (obs !== {es[i], eo[i], ei[i]}) begin
                failures++;
                $display("FAIL load_wait cyc=%0d got=%h exp=%h", i, obs, {es[i], eo[i], ei[i]});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        state_t      es[8] = '{ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH, ST_DECODE,
                               ST_EXEC, ST_FETCH};
        logic [16:0] eo[8] = '{O_IDLE, O_FETCH_GO, O_IDLE, O_BR_NT, O_FETCH_GO, O_IDLE,
                               O_BR_T, O_FETCH_WAIT};
        logic        mr[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        bt[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  ei[8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        do_reset();
        opcode = 7'b1100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            br_taken  = bt[i];
            #1;
            checks++;
            if (obs !== {es[i], eo[i], ei[i]}) begin
                failures++;
                $display("FAIL branch cyc=%0d got=%h exp=%h", i, obs, {es[i], eo[i], ei[i]});
            end
            @(negedge clk);
        end
        br_taken = 1'b0;
    endtask

    task automatic test_store_lui();
        state_t      es[10] = '{ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_FETCH,
                                ST_DECODE, ST_EXEC, ST_WB, ST_FETCH};
        logic [16:0] eo[10] = '{O_IDLE, O_FETCH_GO, O_IDLE, O_EXEC_MEM, O_ST, O_FETCH_GO,
                                O_IDLE, O_EXEC_LUI, O_WB_ALU, O_FETCH_WAIT};
        logic [6:0]  op[10] = '{7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011,
                                7'b0110111, 7'b0110111, 7'b0110111, 7'b0110111, 7'b0110111};
        logic        mr[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0]  ei[10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            opcode    = op[i];
            mem_ready = mr[i];
            #1;
            checks++;
            if (obs !== {es[i], eo[i], ei[i]}) begin
                failures++;
                $display("FAIL store_lui cyc=%0d got=%h exp=%h", i, obs, {es[i], eo[i], ei[i]});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [23:0] exp;
        do_reset();
        opcode = 7'b1111111;
        for (int i = 0; i < 23; i++) begin
            if (i == 0)      exp = {ST_INIT, O_IDLE, 4'd0};
            else if (i == 1) exp = {ST_FETCH, O_FETCH_GO, 4'd0};
            else if (i == 2) exp = {ST_DECODE, O_IDLE, 4'd0};
            else             exp = {ST_TRAP, O_TRAP, 4'd0};
            mem_ready = (i == 1) || (i > 2);
            br_taken  = (i > 2) && i[0];
            #1;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL illegal cyc=%0d got=%h exp=%h", i, obs, exp);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        br_taken  = 1'b0;
    endtask

    task automatic test_alu_err();
        state_t      es[8] = '{ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_TRAP, ST_INIT,
                               ST_INIT, ST_FETCH};
        logic [16:0] eo[8] = '{O_IDLE, O_FETCH_GO, O_IDLE, O_EXEC_R, O_TRAP, O_IDLE,
                               O_IDLE, O_FETCH_GO};
        logic        mr[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        ae[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        rs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        opcode = 7'b0110011;
        for (int i = 0; i < 8; i++) begin
            rstN      = rs[i];
            mem_ready = mr[i];
            alu_err   = ae[i];
            #1;
            checks++;
            if (obs !== {es[i], eo[i], 4'd0}) begin
                failures++;
                $display("FAIL alu_err cyc=%0d got=%h exp=%h", i, obs, {es[i], eo[i], 4'd0});
            end
            @(negedge clk);
        end
        alu_err   = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        state_t      es[5] = '{ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
        logic [16:0] eo[5] = '{O_IDLE, O_FETCH_GO, O_IDLE, O_EXEC_I, O_WB_ALU};
        do_reset();
        opcode    = 7'b0010011;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (obs !== {es[i], eo[i], 4'd0}) begin
                failures++;
                $display("FAIL mid_fetch cyc=%0d got=%h exp=%h", i, obs, {es[i], eo[i], 4'd0});
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== {ST_FETCH, O_FETCH_WAIT, 4'd1}) begin
            failures++;
            $display("FAIL mid_fetch pending got=%h exp=%h", obs, {ST_FETCH, O_FETCH_WAIT, 4'd1});
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (obs !== {ST_INIT, O_IDLE, 4'd0}) begin
            failures++;
            $display("FAIL mid_fetch async_drop got=%h exp=%h", obs, {ST_INIT, O_IDLE, 4'd0});
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_instret_wrap();
        do_reset();
        opcode    = 7'b1101111;
        mem_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (obs !== {ST_FETCH, O_FETCH_GO, 4'(k)}) begin
                failures++;
                $display("FAIL wrap fetch k=%0d got=%h exp=%h", k, obs, {ST_FETCH, O_FETCH_GO, 4'(k)});
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (obs !== {ST_EXEC, O_JAL, 4'(k)}) begin
                failures++;
                $display("FAIL wrap jal k=%0d got=%h exp=%h", k, obs, {ST_EXEC, O_JAL, 4'(k)});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (obs !== {ST_FETCH, O_FETCH_GO, 4'd0}) begin
            failures++;
            $display("FAIL wrap final got=%h exp=%h", obs, {ST_FETCH, O_FETCH_GO, 4'd0});
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_wait();
        test_branch();
        test_store_lui();
        test_illegal();
        test_alu_err();
        test_reset_mid_fetch();
        test_instret_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
